mem_stage: RTL and testbench

- Memory-access pipeline stage between the EX/MEM pipeline register and the MEM/WB pipeline register (`mem_wb`).
- Executes data-memory loads and stores of one or two bytes over a req/ack bus.
- Owns the hardware return-address stack pointer, and pushes/pops the 14-bit return address for call/return.
- Presents the final top/bot data, instruction, write-enables and return address to `mem_wb`, and stalls upstream during multi-cycle accesses.

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/pair loads and stores over a req/ack bus,
// plus the return-address stack pointer used for push/pop of 14-bit return addresses.
module mem_stage #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] STACK_TOP = {ADDR_W{1'b1}}
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              valid_in,
    input  logic [2:0]        mem_op_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        data_top_in,
    input  logic [7:0]        data_bot_in,
    input  logic [31:0]       instruction_in,
    input  logic [1:0]        reg_file_wen_in,
    input  logic [13:0]       ret_addr_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        data_top_out,
    output logic [7:0]        data_bot_out,
    output logic [31:0]       instruction_out,
    output logic [1:0]        reg_file_wen_out,
    output logic [13:0]       ret_addr_out
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LDB  = 3'd1,
        OP_STB  = 3'd2,
        OP_LDP  = 3'd3,
        OP_STP  = 3'd4,
        OP_PUSH = 3'd5,
        OP_POP  = 3'd6,
        OP_RSVD = 3'd7
    } mem_op_t;

    state_t            state;
    logic [ADDR_W-1:0] sp;
    logic [7:0]        b0;
    logic [7:0]        b1;

    mem_op_t           op;
    logic              is_mem;
    logic              is_pair;
    logic              is_write;
    logic [ADDR_W-1:0] acc0_addr;
    logic [ADDR_W-1:0] acc1_addr;
    logic [7:0]        acc0_wdata;
    logic [7:0]        acc1_wdata;

    // Operation decode and per-phase bus address/data, all from live inputs.
    always_comb begin
        op         = mem_op_t'(mem_op_in);
        is_mem     = op inside {OP_LDB, OP_STB, OP_LDP, OP_STP, OP_PUSH, OP_POP};
        is_pair    = op inside {OP_LDP, OP_STP, OP_PUSH, OP_POP};
        is_write   = op inside {OP_STB, OP_STP, OP_PUSH};
        acc0_addr  = addr_in;
        acc1_addr  = addr_in + ADDR_W'(1);
        acc0_wdata = data_top_in;
        acc1_wdata = data_bot_in;
        unique case (op)
            OP_PUSH: begin
                acc0_addr  = sp;
                acc1_addr  = sp - ADDR_W'(1);
                acc0_wdata = {2'b00, ret_addr_in[13:8]};
                acc1_wdata = ret_addr_in[7:0];
            end
            OP_POP: begin
                acc0_addr = sp + ADDR_W'(1);
                acc1_addr = sp + ADDR_W'(2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            sp    <= STACK_TOP;
            b0    <= '0;
            b1    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_in && is_mem)
                        state <= ACC0;
                end
                ACC0: begin
                    if (mem_ack) begin
                        if (!is_write)
                            b0 <= mem_rdata;
                        state <= is_pair ? ACC1 : DONE;
                    end
                end
                ACC1: begin
                    if (mem_ack) begin
                        if (!is_write)
                            b1 <= mem_rdata;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The stack pointer moves only once mem_wb accepts the result.
                    if (op == OP_PUSH)
                        sp <= sp - ADDR_W'(2);
                    else if (op == OP_POP)
                        sp <= sp + ADDR_W'(2);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_out        = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        data_top_out     = '0;
        data_bot_out     = '0;
        instruction_out  = '0;
        reg_file_wen_out = '0;
        ret_addr_out     = '0;
        // Outputs are forced to zero while reset is held, even for pass-through.
        if (nreset) begin
            unique case (state)
                IDLE: begin
                    stall_out = valid_in && is_mem;
                    if (valid_in && !is_mem) begin
                        data_top_out     = data_top_in;
                        data_bot_out     = data_bot_in;
                        instruction_out  = instruction_in;
                        reg_file_wen_out = reg_file_wen_in;
                        ret_addr_out     = ret_addr_in;
                    end
                end
                ACC0: begin
                    stall_out = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = is_write;
                    mem_addr  = acc0_addr;
                    mem_wdata = is_write ? acc0_wdata : 8'h00;
                end
                ACC1: begin
                    stall_out = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = is_write;
                    mem_addr  = acc1_addr;
                    mem_wdata = is_write ? acc1_wdata : 8'h00;
                end
                DONE: begin
                    data_top_out     = data_top_in;
                    data_bot_out     = data_bot_in;
                    instruction_out  = instruction_in;
                    reg_file_wen_out = reg_file_wen_in;
                    ret_addr_out     = ret_addr_in;
                    unique case (op)
                        OP_LDB: data_top_out = b0;
                        OP_LDP: begin
                            data_top_out = b0;
                            data_bot_out = b1;
                        end
                        OP_POP: ret_addr_out = 14'({b1, b0});
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a memory array plus stack-pointer model predicts
// every bus transfer, the stall length and the value presented to mem_wb.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        nreset;
    logic        valid_in;
    logic [2:0]  mem_op_in;
    logic [15:0] addr_in;
    logic [7:0]  data_top_in;
    logic [7:0]  data_bot_in;
    logic [31:0] instruction_in;
    logic [1:0]  reg_file_wen_in;
    logic [13:0] ret_addr_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  data_top_out;
    logic [7:0]  data_bot_out;
    logic [31:0] instruction_out;
    logic [1:0]  reg_file_wen_out;
    logic [13:0] ret_addr_out;
    logic [63:0] outs;

    mem_stage #(.ADDR_W(16), .STACK_TOP(16'hFFFF)) dut (
        .clock           (clock),
        .nreset          (nreset),
        .valid_in        (valid_in),
        .mem_op_in       (mem_op_in),
        .addr_in         (addr_in),
        .data_top_in     (data_top_in),
        .data_bot_in     (data_bot_in),
        .instruction_in  (instruction_in),
        .reg_file_wen_in (reg_file_wen_in),
        .ret_addr_in     (ret_addr_in),
        .stall_out       (stall_out),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .data_top_out    (data_top_out),
        .data_bot_out    (data_bot_out),
        .instruction_out (instruction_out),
        .reg_file_wen_out(reg_file_wen_out),
        .ret_addr_out    (ret_addr_out)
    );

    assign outs = {instruction_out, reg_file_wen_out, data_top_out, data_bot_out, ret_addr_out};

    always #5 clock = ~clock;

    typedef struct {
        bit         we;
        int         addr;
        logic [7:0] wdata;
    } xfer_t;

    logic [7:0] mem_model [0:65535];
    int         sp_model;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One instruction through the stage, with ack waits drawn from [wmin, wmax].
    task automatic run_op(input logic v, input logic [2:0] op, input int a,
                          input logic [7:0] top, input logic [7:0] bot,
                          input logic [13:0] ret, input int wmin, input int wmax);
        xfer_t       exp_q[$];
        int          w[$];
        logic [31:0] instr;
        logic [1:0]  wen;
        logic [7:0]  e_top, e_bot;
        logic [13:0] e_ret;
        logic [63:0] exp_out;
        int          exp_stall, stall_cnt, ti, waitc, cycles, lo, hi;
        bit          acked;

        instr = $urandom;
        wen   = 2'($urandom);
        a     = a & 16'hFFFF;
        e_top = top;
        e_bot = bot;
        e_ret = ret;
        if (v) begin
            case (op)
                3'd1: begin
                    exp_q.push_back('{1'b0, a, 8'h00});
                    e_top = mem_model[a];
                end
                3'd2: begin
                    exp_q.push_back('{1'b1, a, top});
                    mem_model[a] = top;
                end
                3'd3: begin
                    lo = (a + 1) & 16'hFFFF;
                    exp_q.push_back('{1'b0, a, 8'h00});
                    exp_q.push_back('{1'b0, lo, 8'h00});
                    e_top = mem_model[a];
                    e_bot = mem_model[lo];
                end
                3'd4: begin
                    lo = (a + 1) & 16'hFFFF;
                    exp_q.push_back('{1'b1, a, top});
                    exp_q.push_back('{1'b1, lo, bot});
                    mem_model[a]  = top;
                    mem_model[lo] = bot;
                end
                3'd5: begin
                    lo = (sp_model - 1) & 16'hFFFF;
                    exp_q.push_back('{1'b1, sp_model, {2'b00, ret[13:8]}});
                    exp_q.push_back('{1'b1, lo, ret[7:0]});
                    mem_model[sp_model] = {2'b00, ret[13:8]};
                    mem_model[lo]       = ret[7:0];
                    sp_model = (sp_model - 2) & 16'hFFFF;
                end
                3'd6: begin
                    lo = (sp_model + 1) & 16'hFFFF;
                    hi = (sp_model + 2) & 16'hFFFF;
                    exp_q.push_back('{1'b0, lo, 8'h00});
                    exp_q.push_back('{1'b0, hi, 8'h00});
                    e_ret = {mem_model[hi][5:0], mem_model[lo]};
                    sp_model = hi;
                end
                default: ;
            endcase
        end
        exp_stall = 0;
        foreach (exp_q[i]) begin
            w.push_back($urandom_range(wmax, wmin));
            exp_stall += 1 + w[i];
        end
        if (exp_q.size() != 0)
            exp_stall += 1;
        exp_out = v ? {instr, wen, e_top, e_bot, e_ret} : 64'h0;

        @(negedge clock);
        valid_in        = v;
        mem_op_in       = op;
        addr_in         = a[15:0];
        data_top_in     = top;
        data_bot_in     = bot;
        instruction_in  = instr;
        reg_file_wen_in = wen;
        ret_addr_in     = ret;
        mem_ack         = 1'b0;
        stall_cnt = 0;
        ti        = 0;
        cycles    = 0;
        waitc     = (w.size() != 0) ? w[0] : 0;
        forever begin
            #1;
            if (stall_out !== 1'b1)
                break;
            stall_cnt++;
            check("bubble", outs, 64'h0);
            acked = 1'b0;
            if (mem_req) begin
                if (ti < exp_q.size()) begin
                    check("bus_addr", 64'(mem_addr), 64'(exp_q[ti].addr));
                    check("bus_we", 64'(mem_we), 64'(exp_q[ti].we));
                    if (exp_q[ti].we)
                        check("bus_wdata", 64'(mem_wdata), 64'(exp_q[ti].wdata));
                end else begin
                    check("extra_xfer", 64'(ti), 64'(exp_q.size() - 1));
                end
                if (waitc == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 8'($urandom) : mem_model[mem_addr];
                    acked     = 1'b1;
                end else begin
                    waitc--;
                end
            end else begin
                mem_ack   = 1'($urandom_range(1, 0));
                mem_rdata = 8'($urandom);
            end
            @(posedge clock);
            if (acked) begin
                ti++;
                if (ti < w.size())
                    waitc = w[ti];
            end
            @(negedge clock);
            mem_ack = 1'b0;
            cycles++;
            if (cycles > 64) begin
                check("timeout", 64'(cycles), 64'd64);
                break;
            end
        end
        check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
        check("xfer_count", 64'(ti), 64'(exp_q.size()));
        check("result", outs, exp_out);
        check("req_off", 64'(mem_req), 64'h0);
        @(posedge clock);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            mem_model[i] = 8'($urandom);
        sp_model        = 16'hFFFF;
        nreset          = 1'b0;
        valid_in        = 1'b1;
        mem_op_in       = 3'd0;
        addr_in         = 16'h1234;
        data_top_in     = 8'h5A;
        data_bot_in     = 8'hA5;
        instruction_in  = 32'hDEADBEEF;
        reg_file_wen_in = 2'b11;
        ret_addr_in     = 14'h1FFF;
        mem_rdata       = 8'h00;
        mem_ack         = 1'b0;
        #2;
        check("rst_outs", outs, 64'h0);
        check("rst_stall", 64'(stall_out), 64'h0);
        check("rst_req", 64'(mem_req), 64'h0);
        repeat (2) @(negedge clock);
        nreset = 1'b1;

        // Pass-through, load byte, store pair across the wrap, push then pop.
        run_op(1'b1, 3'd0, 0, 8'h5A, 8'h3C, 14'h0123, 0, 0);
        mem_model[16'h0100] = 8'hC3;
        run_op(1'b1, 3'd1, 16'h0100, 8'h00, 8'h77, 14'h0000, 0, 0);
        run_op(1'b1, 3'd4, 16'hFFFF, 8'h11, 8'h22, 14'h0000, 2, 2);
        run_op(1'b1, 3'd5, 0, 8'h01, 8'h02, 14'h2A5C, 0, 1);
        run_op(1'b1, 3'd6, 0, 8'h03, 8'h04, 14'h0000, 0, 1);
        run_op(1'b0, 3'd1, 16'h0040, 8'hFF, 8'hFF, 14'h3FFF, 0, 0);
        run_op(1'b1, 3'd7, 16'h0040, 8'h99, 8'h88, 14'h1111, 0, 0);

        // Asynchronous reset while the second byte of a load pair is outstanding.
        @(negedge clock);
        valid_in  = 1'b1;
        mem_op_in = 3'd3;
        addr_in   = 16'h0200;
        mem_ack   = 1'b0;
        @(negedge clock);
        mem_ack   = 1'b1;
        mem_rdata = 8'h5E;
        @(negedge clock);
        mem_ack = 1'b0;
        #1;
        check("acc1_req", 64'(mem_req), 64'h1);
        check("acc1_addr", 64'(mem_addr), 64'h0201);
        #1;
        nreset = 1'b0;
        #1;
        check("arst_req", 64'(mem_req), 64'h0);
        check("arst_stall", 64'(stall_out), 64'h0);
        check("arst_outs", outs, 64'h0);
        sp_model = 16'hFFFF;
        @(negedge clock);
        nreset   = 1'b1;
        valid_in = 1'b0;
        run_op(1'b1, 3'd5, 0, 8'h00, 8'h00, 14'h15A3, 0, 0);
        run_op(1'b1, 3'd3, 16'h0200, 8'h00, 8'h00, 14'h0000, 0, 2);

        for (int n = 0; n < 300; n++) begin
            int a;
            a = ($urandom_range(3, 0) == 0) ? 16'hFFFF - $urandom_range(2, 0) : $urandom_range(16'hFFFF, 0);
            run_op(1'($urandom_range(7, 0) != 0), 3'($urandom), a, 8'($urandom), 8'($urandom),
                   14'($urandom), 0, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
